dmux8_feeder: RTL and testbench
===============================

// Module: dmux8_feeder
// PURPOSE
//   Upstream stage of the 8-way demultiplexer (dmux8). Accepts {channel, data} words over a valid/ready handshake and buffers them in a small FIFO.
//   Presents each word on d/s, stable for HOLD cycles, then inserts one gap cycle, so the dmux8 output for that channel carries one clean pulse per word.
// PARAMETERS
//   N      6  data width; matches the dmux8 N parameter
//   DEPTH  4  FIFO depth in words; power of 2, >= 2
//   HOLD   2  cycles each word stays on d/s with out_valid high; 0 is treated as 1
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              producer holds a word
//   in_ready   out  1              FIFO can accept; = !full (combinational from count)
//   in_data    in   N              word payload
//   in_ch      in   3              target channel 0..7
//   d          out  N              to dmux8 d; registered
//   s          out  3              to dmux8 s; registered
//   out_valid  out  1              d/s carry a live word
//   level      out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH
// BEHAVIOUR
//   - Reset, asynchronous and immediate: FIFO flushed (level=0, pointers 0), FSM=IDLE, d=0, s=0, out_valid=0, in_ready=1, hold counter=0.
//   - Reset mid-operation: a presented word and all buffered words are discarded. The first edge after rst_n rises behaves as post-reset IDLE.
//   - Push: in_valid & in_ready at an edge writes {in_ch,in_data} at wr_ptr. wr_ptr wraps modulo DEPTH.
//   - Pop: when FSM loads a word. rd_ptr wraps modulo DEPTH.
//   - Simultaneous push and pop: level unchanged. Push only: +1. Pop only: -1.
//   - Full (level=DEPTH): in_ready=0, and in_valid is ignored. Empty: no pop.
//   - FSM, all registered:
//     IDLE:    if level>0: load head into d/s, out_valid=1, cnt=HOLD-1, go to PRESENT.
//     PRESENT: d/s/out_valid stable. If cnt>0: cnt--. Else: d=0, out_valid=0, s holds its value, go to GAP.
//     GAP:     one cycle with out_valid=0, d=0. If level>0: load next word, go to PRESENT. Else go to IDLE.
//   - Throughput: one word per HOLD+1 cycles at best. out_valid is high exactly HOLD consecutive cycles per word.
//   - Latency, base build: push at edge k into an empty FIFO with FSM IDLE -> load at edge k+1 -> out_valid high from edge k+1.
//   - d=0 whenever out_valid=0, so every dmux8 output reads 0 between words.
//   - A word never leaves the FIFO before it is loaded, and words are presented in strict push order.
// CONFIGURATION
//   `DMUX8_FEEDER_BYPASS_EN defined:
//     - When FSM=IDLE and level=0, a handshaken word loads directly into d/s at the push edge k, with out_valid high from edge k.
//     - That word is not written to the FIFO, so level stays 0 for it.
//     - Latency drops to 0 extra cycles. All other rules are unchanged.
//   Undefined: every word passes through the FIFO, with latency as stated above.
// TESTING
//   1. Reset, then push {ch=5,data=6'h2A} into an idle block:
//      out_valid=1, s=5, d=2A for exactly 2 cycles starting edge k+1 (edge k with BYPASS), then 1 gap cycle with d=0.
//   2. Push 4 words back-to-back while the FSM is PRESENT:
//      level reaches 4 and in_ready=0. A 5th in_valid is dropped.
//      Output order is ch 0,1,2,3, spaced exactly 3 cycles apart.
//   3. Push 9 words total across drains, so both pointers wrap twice:
//      all 9 appear in order with correct ch/data, and level returns to 0.
//   4. Push and pop on the same edge at level=2: level stays 2.
//   5. Assert rst_n=0 mid-PRESENT with level=3:
//      d=0, out_valid=0, level=0 immediately with no clock. After release, nothing is presented until a new push.
//   6. HOLD=0 build: out_valid high exactly 1 cycle per word.

Source files
------------

// File: rtl/dmux8_feeder.sv
// Feeder for dmux8: buffers {ch,data} words in a FIFO and presents each for HOLD cycles plus one gap.
// Define DMUX8_FEEDER_BYPASS_EN to let a word skip the empty FIFO and load on its push edge.
module dmux8_feeder #(
    parameter int N     = 6,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_data,
    input  logic [2:0]               in_ch,
    output logic [N-1:0]             d,
    output logic [2:0]               s,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;
    localparam int HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
    localparam int CW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(HOLD_EFF - 1);

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    state_t          state_q, state_d;
    logic [N+2:0]    mem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    d_q, d_d;
    logic [2:0]      s_q, s_d;
    logic            valid_q, valid_d;
    logic            push, fifoWrite, pop, bypassLoad;
    logic [N+2:0]    head;

    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;

`ifdef DMUX8_FEEDER_BYPASS_EN
    assign bypassLoad = push && (state_q == IDLE) && (level_q == '0);
`else
    assign bypassLoad = 1'b0;
`endif

    assign fifoWrite = push && !bypassLoad;
    assign head      = mem_q[rdPtr_q];

    // Storage needs no reset: occupancy is tracked entirely by level and the pointers.
    always_ff @(posedge clk) begin
        if (fifoWrite) begin
            mem_q[wrPtr_q] <= {in_ch, in_data};
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        s_d     = s_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    d_d     = head[N-1:0];
                    s_d     = head[N+2:N];
                    valid_d = 1'b1;
                    cnt_d   = CNT_INIT;
                    pop     = 1'b1;
                    state_d = PRESENT;
                end else if (bypassLoad) begin
                    d_d     = in_data;
                    s_d     = in_ch;
                    valid_d = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    d_d     = '0;
                    valid_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                // s keeps the last channel so the dmux8 select does not glitch between words.
                if (level_q != '0) begin
                    d_d     = head[N-1:0];
                    s_d     = head[N+2:N];
                    valid_d = 1'b1;
                    cnt_d   = CNT_INIT;
                    pop     = 1'b1;
                    state_d = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                d_d     = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wrPtr_d = fifoWrite ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop ? rdPtr_q + AW'(1) : rdPtr_q;
        case ({fifoWrite, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            s_q     <= s_d;
            valid_q <= valid_d;
        end
    end

    assign d         = d_q;
    assign s         = s_q;
    assign out_valid = valid_q;
    assign level     = level_q;

endmodule

// File: tb/tb_dmux8_feeder.sv
// Directed bench for dmux8_feeder: default instance (HOLD=2) plus a HOLD=0 instance.
module tb_dmux8_feeder;
    localparam int N     = 6;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          inValid, inReady, outValid;
    logic [N-1:0]  inData, dOut;
    logic [2:0]    inCh, sOut;
    logic [LW-1:0] level;
    logic          inValidZ, inReadyZ, outValidZ;
    logic [N-1:0]  inDataZ, dOutZ;
    logic [2:0]    inChZ, sOutZ;
    logic [LW-1:0] levelZ;

    int checks   = 0;
    int failures = 0;

    logic [2:0]   chTab   [9] = '{3'd3, 3'd1, 3'd6, 3'd0, 3'd7, 3'd2, 3'd5, 3'd4, 3'd3};
    logic [N-1:0] dataTab [9] = '{6'h11, 6'h22, 6'h33, 6'h05, 6'h2C, 6'h3E, 6'h19, 6'h07, 6'h30};

    dmux8_feeder #(.N(N), .DEPTH(DEPTH), .HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .in_data(inData), .in_ch(inCh), .d(dOut), .s(sOut),
        .out_valid(outValid), .level(level)
    );

    dmux8_feeder #(.N(N), .DEPTH(DEPTH), .HOLD(0)) dutZ (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidZ), .in_ready(inReadyZ),
        .in_data(inDataZ), .in_ch(inChZ), .d(dOutZ), .s(sOutZ),
        .out_valid(outValidZ), .level(levelZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] ch, input logic [N-1:0] data);
        inValid = v;
        inCh    = ch;
        inData  = data;
    endtask

    task automatic applyStimulusZ(input logic v, input logic [2:0] ch, input logic [N-1:0] data);
        inValidZ = v;
        inChZ    = ch;
        inDataZ  = data;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 6'h00);
        applyStimulusZ(1'b0, 3'd0, 6'h00);
        #2;
        checkOutput("rst_level", level, 0);
        checkOutput("rst_ready", inReady, 1);
        checkOutput("rst_valid", outValid, 0);
        checkOutput("rst_d", dOut, 0);
        checkOutput("rst_s", sOut, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single word into an idle block: 2 cycles valid starting one edge after the push.
        applyStimulus(1'b1, 3'd5, 6'h2A);
        tick();
        checkOutput("t1_level_push", level, 1);
        checkOutput("t1_valid_k", outValid, 0);
        applyStimulus(1'b0, 3'd0, 6'h00);
        tick();
        checkOutput("t1_valid_k1", outValid, 1);
        checkOutput("t1_s_k1", sOut, 5);
        checkOutput("t1_d_k1", dOut, 6'h2A);
        checkOutput("t1_level_k1", level, 0);
        tick();
        checkOutput("t1_valid_k2", outValid, 1);
        checkOutput("t1_d_k2", dOut, 6'h2A);
        tick();
        checkOutput("t1_valid_gap", outValid, 0);
        checkOutput("t1_d_gap", dOut, 0);
        checkOutput("t1_s_gap", sOut, 5);
        tick();
        checkOutput("t1_valid_idle", outValid, 0);

        // Fill to full behind a filler word; the word offered while full is dropped.
        applyStimulus(1'b1, 3'd7, 6'h3F);
        tick();
        checkOutput("t2_level_e0", level, 1);
        applyStimulus(1'b1, 3'd0, 6'h01);
        tick();
        checkOutput("t2_filler_valid", outValid, 1);
        checkOutput("t2_filler_s", sOut, 7);
        checkOutput("t2_filler_d", dOut, 6'h3F);
        applyStimulus(1'b1, 3'd1, 6'h02);
        tick();
        checkOutput("t2_level_e2", level, 2);
        applyStimulus(1'b1, 3'd2, 6'h03);
        tick();
        checkOutput("t2_level_e3", level, 3);
        checkOutput("t2_gap_valid", outValid, 0);
        applyStimulus(1'b1, 3'd3, 6'h04);
        tick();
        checkOutput("t2_level_e4", level, 3);
        checkOutput("t2_w0_s", sOut, 0);
        checkOutput("t2_w0_d", dOut, 6'h01);
        applyStimulus(1'b1, 3'd4, 6'h05);
        tick();
        checkOutput("t2_level_full", level, 4);
        checkOutput("t2_ready_full", inReady, 0);
        applyStimulus(1'b1, 3'd6, 6'h2E);
        tick();
        checkOutput("t2_level_drop", level, 4);
        checkOutput("t2_gap2_valid", outValid, 0);
        applyStimulus(1'b0, 3'd0, 6'h00);
        tick();
        checkOutput("t2_w1_valid", outValid, 1);
        checkOutput("t2_w1_s", sOut, 1);
        checkOutput("t2_w1_d", dOut, 6'h02);
        checkOutput("t2_level_e7", level, 3);
        for (int i = 2; i <= 4; i++) begin
            tick();
            tick();
            checkOutput($sformatf("t2_gap_valid_%0d", i), outValid, 0);
            checkOutput($sformatf("t2_gap_d_%0d", i), dOut, 0);
            tick();
            checkOutput($sformatf("t2_valid_%0d", i), outValid, 1);
            checkOutput($sformatf("t2_s_%0d", i), sOut, i);
            checkOutput($sformatf("t2_d_%0d", i), dOut, i + 1);
            checkOutput($sformatf("t2_level_%0d", i), level, 4 - i);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("t2_no_dropped_word", outValid, 0);
        checkOutput("t2_level_end", level, 0);

        // Nine words in bursts of three so both pointers wrap.
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b1, chTab[3*b], dataTab[3*b]);
            tick();
            applyStimulus(1'b1, chTab[3*b+1], dataTab[3*b+1]);
            tick();
            checkOutput($sformatf("t3_s_%0d", 3*b), sOut, chTab[3*b]);
            checkOutput($sformatf("t3_d_%0d", 3*b), dOut, dataTab[3*b]);
            applyStimulus(1'b1, chTab[3*b+2], dataTab[3*b+2]);
            tick();
            applyStimulus(1'b0, 3'd0, 6'h00);
            for (int m = 1; m < 3; m++) begin
                tick();
                tick();
                tick();
                checkOutput($sformatf("t3_valid_%0d", 3*b+m), outValid, 1);
                checkOutput($sformatf("t3_s_%0d", 3*b+m), sOut, chTab[3*b+m]);
                checkOutput($sformatf("t3_d_%0d", 3*b+m), dOut, dataTab[3*b+m]);
            end
            tick();
            tick();
            tick();
            checkOutput($sformatf("t3_level_burst%0d", b), level, 0);
            checkOutput($sformatf("t3_idle_burst%0d", b), outValid, 0);
        end

        // Simultaneous push and pop at level 2, then reset with three words pending.
        applyStimulus(1'b1, 3'd2, 6'h12);
        tick();
        checkOutput("t4_level_c0", level, 1);
        applyStimulus(1'b1, 3'd4, 6'h24);
        tick();
        checkOutput("t4_w0_s", sOut, 2);
        checkOutput("t4_w0_d", dOut, 6'h12);
        applyStimulus(1'b1, 3'd6, 6'h36);
        tick();
        checkOutput("t4_level_c2", level, 2);
        applyStimulus(1'b0, 3'd0, 6'h00);
        tick();
        checkOutput("t4_level_c3", level, 2);
        applyStimulus(1'b1, 3'd1, 6'h01);
        tick();
        checkOutput("t4_level_pushpop", level, 2);
        checkOutput("t4_w1_s", sOut, 4);
        checkOutput("t4_w1_d", dOut, 6'h24);
        applyStimulus(1'b1, 3'd3, 6'h33);
        tick();
        checkOutput("t5_level_pre", level, 3);
        checkOutput("t5_valid_pre", outValid, 1);
        applyStimulus(1'b0, 3'd0, 6'h00);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_valid_rst", outValid, 0);
        checkOutput("t5_d_rst", dOut, 0);
        checkOutput("t5_s_rst", sOut, 0);
        checkOutput("t5_level_rst", level, 0);
        checkOutput("t5_ready_rst", inReady, 1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("t5_valid_after", outValid, 0);
        checkOutput("t5_level_after", level, 0);
        checkOutput("t5_d_after", dOut, 0);
        applyStimulus(1'b1, 3'd5, 6'h1D);
        tick();
        checkOutput("t5_new_level", level, 1);
        applyStimulus(1'b0, 3'd0, 6'h00);
        tick();
        checkOutput("t5_new_valid", outValid, 1);
        checkOutput("t5_new_s", sOut, 5);
        checkOutput("t5_new_d", dOut, 6'h1D);

        // HOLD=0 instance: one valid cycle per word, words two cycles apart.
        applyStimulusZ(1'b1, 3'd3, 6'h2B);
        tick();
        checkOutput("t6_level_h0", levelZ, 1);
        applyStimulusZ(1'b1, 3'd6, 6'h14);
        tick();
        checkOutput("t6_valid_h1", outValidZ, 1);
        checkOutput("t6_s_h1", sOutZ, 3);
        checkOutput("t6_d_h1", dOutZ, 6'h2B);
        applyStimulusZ(1'b0, 3'd0, 6'h00);
        tick();
        checkOutput("t6_valid_h2", outValidZ, 0);
        checkOutput("t6_d_h2", dOutZ, 0);
        tick();
        checkOutput("t6_valid_h3", outValidZ, 1);
        checkOutput("t6_s_h3", sOutZ, 6);
        checkOutput("t6_d_h3", dOutZ, 6'h14);
        tick();
        checkOutput("t6_valid_h4", outValidZ, 0);
        checkOutput("t6_s_h4", sOutZ, 6);
        tick();
        checkOutput("t6_valid_h5", outValidZ, 0);
        checkOutput("t6_level_h5", levelZ, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
